// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the clearable dual-port RAM.
package dp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result pipeline for one RAM port: captures read data plus a valid
// strobe, with an optional second register stage when RD_LATENCY is 2.
module ram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_data;

    // Data only loads on a real read so dout holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_data <= in_data;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_stage2
            logic                  s2_vld;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign out_vld  = s2_vld;
            assign out_data = s2_data;
        end else begin : g_stage1
            assign out_vld  = s1_vld;
            assign out_data = s1_data;
        end
    endgenerate

endmodule

// File: rtl/dp_ram_clr.sv
// True dual-port RAM with a sequential clear engine, configurable read
// latency, read-valid strobes and defined cross-port collision behaviour.
module dp_ram_clr
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_OLD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  coll,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  vld_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  vld_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("dp_ram_clr: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  wr_a, wr_b, rd_a, rd_b;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;

    assign busy      = (state == CLEAR);
    assign same_addr = (addr_a == addr_b);
    assign wr_a      = en_a &  we_a & ~busy;
    assign wr_b      = en_b &  we_b & ~busy;
    assign rd_a      = en_a & ~we_a & ~busy;
    assign rd_b      = en_b & ~we_b & ~busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            coll  <= 1'b0;
        end else begin
            coll <= wr_a & wr_b & same_addr;
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Port A wins a same-address write/write; the clear pass owns the array while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            if (!rst) begin
                mem[cnt] <= '0;
            end
        end else begin
            if (wr_a) begin
                mem[addr_a] <= din_a;
            end
            if (wr_b && !(wr_a && same_addr)) begin
                mem[addr_b] <= din_b;
            end
        end
    end

    always_comb begin
        rd_data_a = mem[addr_a];
        rd_data_b = mem[addr_b];
        if (RDW_MODE == RDW_NEW) begin
            if (wr_b && same_addr) begin
                rd_data_a = din_b;
            end
            if (wr_a && same_addr) begin
                rd_data_b = din_a;
            end
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_a),
        .in_data  (rd_data_a),
        .out_vld  (vld_a),
        .out_data (dout_a)
    );

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_b),
        .in_data  (rd_data_b),
        .out_vld  (vld_b),
        .out_data (dout_b)
    );

endmodule

// File: tb/tb_dp_ram_clr.sv
// Directed bench: two instances share stimulus, one with RD_LATENCY=1/RDW_NEW
// (l1_*) and one with RD_LATENCY=2/RDW_OLD (l2_*).
module tb_dp_ram_clr;
    import dp_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clr_req;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;

    logic        l1_busy, l1_coll, l1_vld_a, l1_vld_b;
    logic [15:0] l1_dout_a, l1_dout_b;
    logic        l2_busy, l2_coll, l2_vld_a, l2_vld_b;
    logic [15:0] l2_dout_a, l2_dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_ram_clr #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .RD_LATENCY (1),
        .RDW_MODE   (RDW_NEW)
    ) u_lat1 (
        .clk (clk), .rst (rst), .clr_req (clr_req),
        .busy (l1_busy), .coll (l1_coll),
        .en_a (en_a), .we_a (we_a), .addr_a (addr_a), .din_a (din_a),
        .dout_a (l1_dout_a), .vld_a (l1_vld_a),
        .en_b (en_b), .we_b (we_b), .addr_b (addr_b), .din_b (din_b),
        .dout_b (l1_dout_b), .vld_b (l1_vld_b)
    );

    dp_ram_clr #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .RD_LATENCY (2),
        .RDW_MODE   (RDW_OLD)
    ) u_lat2 (
        .clk (clk), .rst (rst), .clr_req (clr_req),
        .busy (l2_busy), .coll (l2_coll),
        .en_a (en_a), .we_a (we_a), .addr_a (addr_a), .din_a (din_a),
        .dout_a (l2_dout_a), .vld_a (l2_vld_a),
        .en_b (en_b), .we_b (we_b), .addr_b (addr_b), .din_b (din_b),
        .dout_b (l2_dout_b), .vld_b (l2_vld_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports;
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    endtask

    // Counts busy cycles on both instances; any vld during busy is an error.
    task automatic wait_clear(input int exp_cycles, input string tag);
        int n = 0;
        int vld_seen = 0;
        while ((l1_busy || l2_busy) && n < 100) begin
            tick();
            n++;
            if (l1_busy && (l1_vld_a || l1_vld_b || l2_vld_a || l2_vld_b)) vld_seen++;
        end
        checks++;
        if (n !== exp_cycles) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, exp_cycles);
        end
        checks++;
        if (vld_seen !== 0) begin
            errors++;
            $display("FAIL %s vld_during_busy: got %0d expected 0", tag, vld_seen);
        end
        checks++;
        if (l1_busy !== 1'b0 || l2_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end: got %b/%b expected 0/0", tag, l1_busy, l2_busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; clr_req = 1'b0; idle_ports();
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        tick(); tick();
        checks++;
        if ({l1_busy, l1_coll, l1_vld_a, l1_vld_b} !== 4'b1000) begin
            errors++;
            $display("FAIL reset l1_flags: got %b expected 1000", {l1_busy, l1_coll, l1_vld_a, l1_vld_b});
        end
        checks++;
        if ({l2_busy, l2_coll, l2_vld_a, l2_vld_b} !== 4'b1000) begin
            errors++;
            $display("FAIL reset l2_flags: got %b expected 1000", {l2_busy, l2_coll, l2_vld_a, l2_vld_b});
        end
        checks++;
        if ({l1_dout_a, l1_dout_b, l2_dout_a, l2_dout_b} !== 64'h0) begin
            errors++;
            $display("FAIL reset dout: got %h expected 0", {l1_dout_a, l1_dout_b, l2_dout_a, l2_dout_b});
        end
        checks++;
        if (u_lat1.cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset cnt: got %0d expected 0", u_lat1.cnt);
        end
        rst = 1'b0;
        wait_clear(16, "reset");
    endtask

    task automatic test_clear;
        int bad = 0;
        for (int i = 0; i < 16; i += 2) begin
            en_a = 1'b1; we_a = 1'b1; addr_a = 4'(i);     din_a = 16'hFFFF;
            en_b = 1'b1; we_b = 1'b1; addr_b = 4'(i + 1); din_b = 16'hFFFF;
            tick();
        end
        idle_ports();
        en_a = 1'b1; addr_a = 4'h6;
        tick();
        idle_ports();
        checks++;
        if (l1_dout_a !== 16'hFFFF) begin
            errors++;
            $display("FAIL clear preload: got %h expected ffff", l1_dout_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(16, "clear");
        for (int i = 0; i < 16; i++) begin
            en_a = 1'b1; addr_a = 4'(i);
            tick();
            if (l1_vld_a !== 1'b1 || l1_dout_a !== 16'h0000) bad++;
        end
        idle_ports();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear readback: got %0d nonzero expected 0", bad);
        end
        tick();
        checks++;
        if (l2_vld_a !== 1'b1 || l2_dout_a !== 16'h0000) begin
            errors++;
            $display("FAIL clear l2_last: got vld=%b dout=%h expected vld=1 dout=0000", l2_vld_a, l2_dout_a);
        end
    endtask

    task automatic test_latency;
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'h5; din_a = 16'h1234;
        tick();
        idle_ports();
        en_b = 1'b1; addr_b = 4'h5;
        tick();
        idle_ports();
        checks++;
        if (l1_vld_b !== 1'b1 || l1_dout_b !== 16'h1234 || l2_vld_b !== 1'b0) begin
            errors++;
            $display("FAIL latency t1: got l1 vld=%b dout=%h l2 vld=%b expected 1 1234 0", l1_vld_b, l1_dout_b, l2_vld_b);
        end
        tick();
        checks++;
        if (l2_vld_b !== 1'b1 || l2_dout_b !== 16'h1234 || l1_vld_b !== 1'b0 || l1_dout_b !== 16'h1234) begin
            errors++;
            $display("FAIL latency t2: got l2 vld=%b dout=%h l1 vld=%b dout=%h expected 1 1234 0 1234",
                     l2_vld_b, l2_dout_b, l1_vld_b, l1_dout_b);
        end
        tick();
        checks++;
        if (l2_vld_b !== 1'b0 || l2_dout_b !== 16'h1234) begin
            errors++;
            $display("FAIL latency hold: got vld=%b dout=%h expected 0 1234", l2_vld_b, l2_dout_b);
        end
    endtask

    task automatic test_collision;
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'h3; din_a = 16'hAAAA;
        en_b = 1'b1; we_b = 1'b1; addr_b = 4'h3; din_b = 16'hBBBB;
        tick();
        checks++;
        if (l1_coll !== 1'b1 || l2_coll !== 1'b1) begin
            errors++;
            $display("FAIL coll pulse: got %b/%b expected 1/1", l1_coll, l2_coll);
        end
        addr_a = 4'h8; din_a = 16'h1111;
        addr_b = 4'h9; din_b = 16'h2222;
        tick();
        checks++;
        if (l1_coll !== 1'b0 || l2_coll !== 1'b0) begin
            errors++;
            $display("FAIL coll diff_addr: got %b/%b expected 0/0", l1_coll, l2_coll);
        end
        idle_ports();
        en_a = 1'b1; addr_a = 4'h3;
        en_b = 1'b1; addr_b = 4'h9;
        tick();
        idle_ports();
        checks++;
        if (l1_dout_a !== 16'hAAAA || l1_dout_b !== 16'h2222) begin
            errors++;
            $display("FAIL coll l1_read: got %h %h expected aaaa 2222", l1_dout_a, l1_dout_b);
        end
        tick();
        checks++;
        if (l2_dout_a !== 16'hAAAA || l2_dout_b !== 16'h2222 || l2_coll !== 1'b0) begin
            errors++;
            $display("FAIL coll l2_read: got %h %h coll=%b expected aaaa 2222 0", l2_dout_a, l2_dout_b, l2_coll);
        end
    endtask

    task automatic test_rdw;
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'h7; din_a = 16'h0001;
        tick();
        din_a = 16'h0002;
        en_b = 1'b1; we_b = 1'b0; addr_b = 4'h7;
        tick();
        idle_ports();
        checks++;
        if (l1_dout_b !== 16'h0002) begin
            errors++;
            $display("FAIL rdw new: got %h expected 0002", l1_dout_b);
        end
        tick();
        checks++;
        if (l2_dout_b !== 16'h0001) begin
            errors++;
            $display("FAIL rdw old: got %h expected 0001", l2_dout_b);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  addrs [5] = '{4'h5, 4'h3, 4'h8, 4'h9, 4'h7};
        logic [15:0] exp   [5] = '{16'h1234, 16'hAAAA, 16'h1111, 16'h2222, 16'h0002};
        int bad = 0;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                en_a = 1'b1; addr_a = addrs[i];
                en_b = 1'b1; addr_b = addrs[4 - i];
            end else begin
                idle_ports();
            end
            tick();
            if (i < 5) begin
                if (l1_vld_a !== 1'b1 || l1_dout_a !== exp[i] ||
                    l1_vld_b !== 1'b1 || l1_dout_b !== exp[4 - i]) bad++;
            end
            if (i > 0) begin
                if (l2_vld_a !== 1'b1 || l2_dout_a !== exp[i - 1] ||
                    l2_vld_b !== 1'b1 || l2_dout_b !== exp[5 - i]) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_mid_clear;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checks++;
        if (l1_busy !== 1'b1 || l2_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear busy: got %b/%b expected 1/1", l1_busy, l2_busy);
        end
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'h2; din_a = 16'h5555;
        en_b = 1'b1; we_b = 1'b0; addr_b = 4'h8;
        clr_req = 1'b1;
        tick();
        idle_ports();
        clr_req = 1'b0;
        checks++;
        if ({l1_vld_a, l1_vld_b, l2_vld_a, l2_vld_b} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_clear vld: got %b expected 0000", {l1_vld_a, l1_vld_b, l2_vld_a, l2_vld_b});
        end
        wait_clear(15, "mid_clear");
        en_a = 1'b1; addr_a = 4'h2;
        en_b = 1'b1; addr_b = 4'h8;
        tick();
        idle_ports();
        checks++;
        if (l1_vld_a !== 1'b1 || l1_dout_a !== 16'h0000 || l1_dout_b !== 16'h0000) begin
            errors++;
            $display("FAIL mid_clear readback: got vld=%b %h %h expected 1 0000 0000", l1_vld_a, l1_dout_a, l1_dout_b);
        end
        tick();
    endtask

    task automatic test_rst_mid_read;
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'h5; din_a = 16'h00C3;
        tick();
        we_a = 1'b0;
        tick();
        idle_ports();
        checks++;
        if (l1_vld_a !== 1'b1 || l1_dout_a !== 16'h00C3) begin
            errors++;
            $display("FAIL rst_mid_read pre: got vld=%b dout=%h expected 1 00c3", l1_vld_a, l1_dout_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({l1_vld_a, l2_vld_a} !== 2'b00 || {l1_dout_a, l2_dout_a} !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_read flush: got vld=%b%b dout=%h %h expected 00 0000 0000",
                     l1_vld_a, l2_vld_a, l1_dout_a, l2_dout_a);
        end
        tick();
        checks++;
        if (l2_vld_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_read stale: got %b expected 0", l2_vld_a);
        end
        rst = 1'b0;
        wait_clear(16, "rst_mid_read");
    endtask

    task automatic test_rst_mid_clear;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (u_lat1.cnt !== 4'd9) begin
            errors++;
            $display("FAIL rst_mid_clear cnt_pre: got %0d expected 9", u_lat1.cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (u_lat1.cnt !== 4'd0 || l1_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_clear restart: got cnt=%0d busy=%b expected 0 1", u_lat1.cnt, l1_busy);
        end
        tick();
        rst = 1'b0;
        wait_clear(16, "rst_mid_clear");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_latency();
        test_collision();
        test_rdw();
        test_back_to_back();
        test_mid_clear();
        test_rst_mid_read();
        test_rst_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
